// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: decoded-character valid/ready stream from the UART receiver FIFO head
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_valid;
    logic                 rx_ready;
    modport master (output rx_data, rx_frame_err, rx_parity_err, rx_valid, input rx_ready);
    modport slave  (input rx_data, rx_frame_err, rx_parity_err, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with runtime half-bit divider, parity/framing checks and FWFT FIFO
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int CLKDIV_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CLKDIV_W-1:0]           cfg_half_period,
    input  logic                          ser_rx,
    uart_rx_sampler_if.master             rx,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;
    localparam logic [CLKDIV_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic                 s1_q, s2_q, prev_q;
    logic [CLKDIV_W:0]    cnt_q, cnt_d;
    logic [CLKDIV_W-1:0]  h_q, h_d, hv;
    logic [BW-1:0]        bc_q, bc_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_q, perr_d;
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]          lvl_q, lvl_d;
    logic                 ovf_q, ovf_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [CLKDIV_W:0]    rel;
    logic                 fall, tick, push, ferr, valid, pop, full, do_push, drop;

    assign fall  = prev_q && !s2_q;
    assign tick  = cnt_q == '0;
    assign hv    = (cfg_half_period == '0) ? CLKDIV_W'(1) : cfg_half_period;
    assign rel   = {h_q, 1'b0} - ONE;
    assign valid = lvl_q != '0;
    assign pop   = valid && rx.rx_ready;
    assign full  = lvl_q == (AW+1)'(FIFO_DEPTH);
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign head  = mem_q[rp_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q != IDLE && !tick) ? cnt_q - ONE : cnt_q;
        h_d     = h_q;
        bc_d    = bc_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                h_d     = hv;
                cnt_d   = {1'b0, hv} - ONE;
                bc_d    = '0;
                perr_d  = 1'b0;
                state_d = START;
            end
            START: if (tick) begin
                cnt_d   = rel;
                state_d = s2_q ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_d   = rel;
                sh_d    = {s2_q, sh_q[DATA_BITS-1:1]};
                bc_d    = (bc_q == BW'(DATA_BITS-1)) ? '0 : bc_q + BW'(1);
                state_d = (bc_q != BW'(DATA_BITS-1)) ? DATA : (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (tick) begin
                cnt_d   = rel;
                perr_d  = ((^sh_q) ^ s2_q) != (PARITY == 2);
                state_d = STOP;
            end
            STOP: if (tick) begin
                push    = 1'b1;
                ferr    = !s2_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wp_d  = wp_q + AW'(do_push);
        rp_d  = rp_q + AW'(pop);
        lvl_d = lvl_q + (AW+1)'(do_push) - (AW+1)'(pop);
        ovf_d = drop ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            bc_q    <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= ser_rx;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            bc_q    <= bc_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= {perr_q, ferr, sh_q};
    end

    assign rx.rx_valid      = valid;
    assign rx.rx_data       = valid ? head[DATA_BITS-1:0] : '0;
    assign rx.rx_frame_err  = valid && head[EW-2];
    assign rx.rx_parity_err = valid && head[EW-1];
    assign overflow         = ovf_q;
    assign fifo_level       = lvl_q;
    assign busy             = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed scoreboard bench for an 8N1 receiver and an 8E1 receiver
module tb_uart_rx_sampler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg = 16'd53;
    logic        ser0 = 1'b1, ser1 = 1'b1;
    logic        clr = 1'b0;
    logic        ovf0, ovf1, busy0, busy1;
    logic [2:0]  lvl0, lvl1;
    int          n_cmp = 0, n_err = 0, cyc = 0, vcyc = 0;
    logic        v0p = 1'b0;
    logic [9:0]  q0[$], q1[$];
    logic [9:0]  e;

    uart_rx_sampler_if #(.DATA_BITS(8)) if0 ();
    uart_rx_sampler_if #(.DATA_BITS(8)) if1 ();

    uart_rx_sampler #(.DATA_BITS(8), .PARITY(0), .CLKDIV_W(16), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .cfg_half_period(cfg), .ser_rx(ser0), .rx(if0),
        .overflow(ovf0), .clr_overflow(clr), .fifo_level(lvl0), .busy(busy0));
    uart_rx_sampler #(.DATA_BITS(8), .PARITY(1), .CLKDIV_W(16), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .cfg_half_period(cfg), .ser_rx(ser1), .rx(if1),
        .overflow(ovf1), .clr_overflow(clr), .fifo_level(lvl1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if0.rx_valid && !v0p) vcyc = cyc;
        v0p = if0.rx_valid;
        if (!reset && if0.rx_valid && if0.rx_ready) begin
            if (q0.size() == 0) chk("rx0_unexpected", {if0.rx_parity_err, if0.rx_frame_err, if0.rx_data}, 10'h3ff);
            else begin
                e = q0.pop_front();
                chk("rx0_entry", {if0.rx_parity_err, if0.rx_frame_err, if0.rx_data}, e);
            end
        end
        if (!reset && if1.rx_valid && if1.rx_ready) begin
            if (q1.size() == 0) chk("rx1_unexpected", {if1.rx_parity_err, if1.rx_frame_err, if1.rx_data}, 10'h3ff);
            else begin
                e = q1.pop_front();
                chk("rx1_entry", {if1.rx_parity_err, if1.rx_frame_err, if1.rx_data}, e);
            end
        end
    end

    task automatic drive(input int w, input logic v, input int n);
        if (w == 0) ser0 = v; else ser1 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int w, input logic [7:0] d, input int h, input logic usep,
                        input logic pb, input logic sb);
        int bp;
        bp  = 2 * ((h < 1) ? 1 : h);
        cfg = 16'(h);
        drive(w, 1'b0, bp);
        for (int i = 0; i < 8; i++) drive(w, d[i], bp);
        if (usep) drive(w, pb, bp);
        drive(w, sb, bp);
        if (sb) drive(w, 1'b1, 8);
    endtask

    initial begin
        int c0;
        logic [7:0] a5;
        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", if0.rx_valid, 0);
        chk("rst_data", if0.rx_data, 0);
        chk("rst_errs", {if0.rx_parity_err, if0.rx_frame_err}, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_busy", busy0, 0);
        reset = 1'b0;
        drive(0, 1'b1, 10);

        q0.push_back({2'b00, 8'h41});
        c0 = cyc;
        send(0, 8'h41, 53, 1'b0, 1'b0, 1'b1);
        chk("latency", vcyc - c0, 2 + 53 + 9 * 106 + 1);
        chk("t1_drained", q0.size(), 0);

        c0 = cyc;
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 20);
        chk("glitch_busy", busy0, 1);
        drive(0, 1'b1, 30);
        chk("glitch_idle", busy0, 0);
        chk("glitch_level", lvl0, 0);

        q0.push_back({2'b01, 8'h55});
        send(0, 8'h55, 53, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 300);
        chk("break_no_retrig", busy0, 0);
        drive(0, 1'b1, 20);
        chk("break_release", busy0, 0);
        chk("t3_drained", q0.size(), 0);

        q1.push_back({2'b10, 8'h03});
        send(1, 8'h03, 53, 1'b1, 1'b1, 1'b1);
        q1.push_back({2'b00, 8'h03});
        send(1, 8'h03, 53, 1'b1, 1'b0, 1'b1);
        chk("t4_drained", q1.size(), 0);

        if0.rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) q0.push_back({2'b00, 8'h10 + 8'(i)});
            send(0, 8'h10 + 8'(i), 53, 1'b0, 1'b0, 1'b1);
        end
        chk("full_level", lvl0, 4);
        chk("ovf_set", ovf0, 1);
        if0.rx_ready = 1'b1;
        drive(0, 1'b1, 6);
        chk("drain_level", lvl0, 0);
        chk("t5_drained", q0.size(), 0);
        chk("ovf_sticky", ovf0, 1);
        clr = 1'b1;
        drive(0, 1'b1, 1);
        clr = 1'b0;
        chk("ovf_clr", ovf0, 0);

        a5 = 8'hA5;
        cfg = 16'd53;
        drive(0, 1'b0, 106);
        for (int i = 0; i < 3; i++) drive(0, a5[i], 106);
        chk("mid_busy", busy0, 1);
        reset = 1'b1;
        drive(0, 1'b1, 2);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_level", lvl0, 0);
        chk("mid_rst_valid", if0.rx_valid, 0);
        reset = 1'b0;
        drive(0, 1'b1, 20);
        chk("mid_rst_nopush", lvl0, 0);
        q0.push_back({2'b00, 8'h3C});
        send(0, 8'h3C, 53, 1'b0, 1'b0, 1'b1);
        q0.push_back({2'b00, 8'h96});
        send(0, 8'h96, 1, 1'b0, 1'b0, 1'b1);
        q0.push_back({2'b00, 8'h5A});
        send(0, 8'h5A, 0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 10);
        chk("t6_drained", q0.size(), 0);
        chk("final_q1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
